systolic_mm_engine: RTL and testbench

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_pe.sv | 68 ++++++
 rtl/systolic_mm_engine.sv | 180 ++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply engine.
// Contents:
//   state_t      - engine phase: FEED (accept operands), DRAIN (flush the
//                  skewed wavefront), OUT (emit result rows)
//   drain_cnt_w  - width of the drain counter, which must hold 0..2N-1
//   row_cnt_w    - width of the output row counter, which must hold 0..N-1
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_FEED  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    function automatic int drain_cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

    function automatic int row_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary array.
// Every cycle it multiplies the operands arriving from the left (a_in) and
// from above (b_in), adds the product into its local accumulator, and
// forwards both operands one register downstream.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clr           - synchronous clear of accumulator and pass registers
//   a_in / a_out  - A operand from the left / to the right neighbour
//   b_in / b_out  - B operand from above / to the neighbour below
//   acc           - running sum for this C element, modulo 2^ACC_W
module systolic_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] prod_ext;

    // Operands are widened to the full product width before multiplying, so
    // the truncated product is exact in both signed and unsigned modes.
    always_comb begin
        if (SIGNED) begin
            a_ext = PW'($signed(a_in));
            b_ext = PW'($signed(b_in));
        end else begin
            a_ext = PW'(a_in);
            b_ext = PW'(b_in);
        end
        prod = a_ext * b_ext;
        if (SIGNED) prod_ext = ACC_W'($signed(prod));
        else        prod_ext = ACC_W'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments so every PE samples
    // its neighbours' values from before the edge, giving one hop per cycle.
    // NOTE: the accumulator is reset explicitly; an abort must never leak a
    // stale partial sum into the next job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matrix multiplier, C = A x B.
// Each accepted beat carries column k of A and row k of B. Lanes are skewed
// (lane i delayed i cycles) so matching terms meet in PE(i,j). After the
// in_last beat the array drains for 2N-1 cycles, then C is emitted one row
// per out_valid/out_ready handshake, and the array clears for the next job.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   in_valid/in_ready/in_last      - operand beat handshake, last term of K
//   in_a, in_b                     - column k of A, row k of B (N lanes each)
//   out_valid/out_ready/out_last   - result row handshake, last row marker
//   out_row                        - row r of C, element j at [j*ACC_W +: ACC_W]
//   busy                           - high while draining or emitting
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [N*DATA_W-1:0] in_a,
    input  logic [N*DATA_W-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*ACC_W-1:0]  out_row,
    output logic                out_last,
    output logic                busy
);

    localparam int DCW = drain_cnt_w(N);
    localparam int RCW = row_cnt_w(N);

    state_t         state;
    logic [DCW-1:0] drain_cnt;
    logic [RCW-1:0] row_cnt;
    logic           fire;
    logic           clr;

    logic [DATA_W-1:0] a_skew [N];
    logic [DATA_W-1:0] b_skew [N];
    logic [DATA_W-1:0] a_pass [N][N];
    logic [DATA_W-1:0] b_pass [N][N];
    logic [ACC_W-1:0]  acc    [N][N];

    assign fire = in_valid && (state == ST_FEED);
    // Final row handed off: wipe the array so the next job starts from zero.
    assign clr  = (state == ST_OUT) && out_ready && (row_cnt == RCW'(N - 1));

    assign in_ready  = (state == ST_FEED);
    assign out_valid = (state == ST_OUT);
    assign out_last  = (state == ST_OUT) && (row_cnt == RCW'(N - 1));
    assign busy      = (state == ST_DRAIN) || (state == ST_OUT);

    // Input skew. Cycles without a handshake inject zeros, which add nothing
    // to any accumulator, so bubbles and the drain phase are harmless.
    for (genvar l = 0; l < N; l++) begin : g_lane
        logic [DATA_W-1:0] a_lane;
        logic [DATA_W-1:0] b_lane;

        assign a_lane = fire ? in_a[l*DATA_W +: DATA_W] : '0;
        assign b_lane = fire ? in_b[l*DATA_W +: DATA_W] : '0;

        if (l == 0) begin : g_direct
            assign a_skew[l] = a_lane;
            assign b_skew[l] = b_lane;
        end else begin : g_delay
            logic [DATA_W-1:0] a_sr [l];
            logic [DATA_W-1:0] b_sr [l];

            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr) begin
                    for (int k = 0; k < l; k++) begin
                        a_sr[k] <= '0;
                        b_sr[k] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_lane;
                    b_sr[0] <= b_lane;
                    for (int k = 1; k < l; k++) begin
                        a_sr[k] <= a_sr[k-1];
                        b_sr[k] <= b_sr[k-1];
                    end
                end
            end

            assign a_skew[l] = a_sr[l-1];
            assign b_skew[l] = b_sr[l-1];
        end
    end

    // PE grid: A moves right along rows, B moves down columns.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_src;
            logic [DATA_W-1:0] b_src;

            if (j == 0) begin : g_a_edge
                assign a_src = a_skew[i];
            end else begin : g_a_int
                assign a_src = a_pass[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_src = b_skew[j];
            end else begin : g_b_int
                assign b_src = b_pass[i-1][j];
            end

            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .a_in  (a_src),
                .b_in  (b_src),
                .a_out (a_pass[i][j]),
                .b_out (b_pass[i][j]),
                .acc   (acc[i][j])
            );
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves out_row unassigned and no latch is inferred.
    always_comb begin
        out_row = '0;
        if (state == ST_OUT) begin
            for (int j = 0; j < N; j++) begin
                out_row[j*ACC_W +: ACC_W] = acc[row_cnt][j];
            end
        end
    end

    // Drain lasts 2N-1 cycles: the last term reaches PE(N-1,N-1) after
    // (N-1) skew cycles plus (N-1) hops, and accumulates one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FEED;
            drain_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            case (state)
                ST_FEED: begin
                    if (fire && in_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DCW'(2 * N - 2)) begin
                        state   <= ST_OUT;
                        row_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (row_cnt == RCW'(N - 1)) begin
                            state   <= ST_FEED;
                            row_cnt <= '0;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_FEED;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine (N=4, DATA_W=16, ACC_W=32).
// Two instances share all stimulus: one unsigned, one signed. Expected
// results come from constants, a table of K=1 jobs, or a plain
// sum-of-products model over the job matrices.
module tb_systolic_mm_engine;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int RW = N * AW;
    localparam int KMAX = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready;
    logic [N*DW-1:0] in_a, in_b;

    logic          in_ready_u, out_valid_u, out_last_u, busy_u;
    logic          in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [RW-1:0] out_row_u, out_row_s;

    always #5 clk = ~clk;

    systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_row(out_row_u), .out_last(out_last_u),
        .busy(busy_u)
    );

    systolic_mm_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_row(out_row_s), .out_last(out_last_s),
        .busy(busy_s)
    );

    int errors = 0;
    int checks = 0;

    // Current job: ja[k][i] = A[i][k], jb[k][j] = B[k][j].
    logic [DW-1:0] ja [KMAX][N];
    logic [DW-1:0] jb [KMAX][N];
    int            jk;
    logic [RW-1:0] exp_u [N];
    logic [RW-1:0] exp_s [N];

    typedef struct {
        logic [N*DW-1:0]        a;
        logic [N*DW-1:0]        b;
        logic [N-1:0][RW-1:0]   eu;
        logic [N-1:0][RW-1:0]   es;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] row4(input logic [31:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], kept modulo 2^32.
    task automatic model_job();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint su = 0;
                longint ss = 0;
                for (int k = 0; k < jk; k++) begin
                    su += longint'(ja[k][i]) * longint'(jb[k][j]);
                    ss += longint'($signed(ja[k][i])) * longint'($signed(jb[k][j]));
                end
                exp_u[i][j*AW +: AW] = su[31:0];
                exp_s[i][j*AW +: AW] = ss[31:0];
            end
        end
    endtask

    task automatic load_identity_job();
        jk = 4;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < N; l++) begin
                ja[k][l] = (l == k) ? 16'd1 : 16'd0;
                jb[k][l] = DW'(4 * k + l + 1);
            end
        for (int r = 0; r < N; r++) begin
            exp_u[r] = row4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
            exp_s[r] = exp_u[r];
        end
    endtask

    // gap: 0 back-to-back, 1 bubble between beats, 2 random bubbles.
    // Garbage with in_last=1 is driven during bubbles; it must be ignored.
    task automatic feed(input int gap);
        for (int k = 0; k < jk; k++) begin
            int nb;
            nb = (gap == 1 && k > 0) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int b = 0; b < nb; b++) begin
                in_valid = 1'b0;
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
                in_last = 1'b1;
                check("in_ready_bubble", RW'(in_ready_u), RW'(1));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_last = (k == jk - 1);
            for (int l = 0; l < N; l++) begin
                in_a[l*DW +: DW] = ja[k][l];
                in_b[l*DW +: DW] = jb[k][l];
            end
            check("in_ready_beat", RW'(in_ready_u), RW'(1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
    endtask

    // Counts edges from the in_last acceptance to out_valid (bounded).
    task automatic wait_result();
        int edges;
        edges = 0;
        check("busy_drain", RW'({busy_u, in_ready_u}), RW'(2'b10));
        while (!out_valid_u && edges < 50) begin
            @(negedge clk);
            edges++;
        end
        check("latency", RW'(edges), RW'(2 * N - 1));
        check("out_valid_s", RW'(out_valid_s), RW'(1));
    endtask

    // stall: 0 none, 1 ten cycles before row 0, 2 random per row.
    task automatic collect(input int stall);
        for (int r = 0; r < N; r++) begin
            int ns;
            ns = (stall == 1 && r == 0) ? 10 : (stall == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < ns; s++) begin
                out_ready = 1'b0;
                check("held_row_u", out_row_u, exp_u[r]);
                check("held_row_s", out_row_s, exp_s[r]);
                check("held_ctl", RW'({out_valid_u, busy_u, in_ready_u}), RW'(3'b110));
                @(negedge clk);
            end
            out_ready = 1'b1;
            check("out_valid", RW'(out_valid_u), RW'(1));
            check("row_u", out_row_u, exp_u[r]);
            check("row_s", out_row_s, exp_s[r]);
            check("out_last", RW'({out_last_u, out_last_s}), (r == N - 1) ? RW'(2'b11) : RW'(0));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("idle_after", RW'({out_valid_u, busy_u, in_ready_u}), RW'(3'b001));
    endtask

    task automatic run_job(input int gap, input int stall);
        feed(gap);
        wait_result();
        collect(stall);
    endtask

    initial begin
        // K=1 outer products: row i = a_i * b.
        vecs[0].a = {16'd4, 16'd3, 16'd2, 16'd1};
        vecs[0].b = {16'd8, 16'd7, 16'd6, 16'd5};
        vecs[0].eu[0] = row4(5, 6, 7, 8);
        vecs[0].eu[1] = row4(10, 12, 14, 16);
        vecs[0].eu[2] = row4(15, 18, 21, 24);
        vecs[0].eu[3] = row4(20, 24, 28, 32);
        vecs[0].es = vecs[0].eu;
        vecs[1].a = {16'd2, 16'd0, 16'd1, 16'd0};
        vecs[1].b = {16'd0, 16'd1, 16'd0, 16'd3};
        vecs[1].eu[0] = '0;
        vecs[1].eu[1] = row4(3, 0, 1, 0);
        vecs[1].eu[2] = '0;
        vecs[1].eu[3] = row4(6, 0, 2, 0);
        vecs[1].es = vecs[1].eu;
        vecs[2].a = {16'd0, 16'd0, 16'd1, 16'hFFFF};
        vecs[2].b = {16'd0, 16'd0, 16'd2, 16'hFFFF};
        vecs[2].eu[0] = row4(32'hFFFE0001, 32'h0001FFFE, 0, 0);
        vecs[2].eu[1] = row4(32'h0000FFFF, 2, 0, 0);
        vecs[2].eu[2] = '0;
        vecs[2].eu[3] = '0;
        vecs[2].es[0] = row4(1, 32'hFFFFFFFE, 0, 0);
        vecs[2].es[1] = row4(32'hFFFFFFFF, 2, 0, 0);
        vecs[2].es[2] = '0;
        vecs[2].es[3] = '0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctl", RW'({out_valid_u, out_last_u, busy_u, out_valid_s, busy_s}), RW'(0));
        check("reset_row", out_row_u | out_row_s, RW'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", RW'({in_ready_u, in_ready_s}), RW'(2'b11));

        // Identity A times B = 1..16, back-to-back.
        load_identity_job();
        run_job(0, 0);

        // Same job with bubbles every other cycle.
        load_identity_job();
        run_job(1, 0);

        // Table of K=1 jobs.
        for (int v = 0; v < 3; v++) begin
            jk = 1;
            for (int l = 0; l < N; l++) begin
                ja[0][l] = vecs[v].a[l*DW +: DW];
                jb[0][l] = vecs[v].b[l*DW +: DW];
            end
            for (int r = 0; r < N; r++) begin
                exp_u[r] = vecs[v].eu[r];
                exp_s[r] = vecs[v].es[r];
            end
            run_job(0, 0);
        end

        // A all 0xFFFF, B all 2, K=4, with a 10-cycle stall at row 0.
        jk = 4;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < N; l++) begin
                ja[k][l] = 16'hFFFF;
                jb[k][l] = 16'd2;
            end
        for (int r = 0; r < N; r++) begin
            exp_u[r] = {4{32'd524280}};
            exp_s[r] = {4{32'hFFFFFFF8}};
        end
        run_job(0, 1);

        // Reset in the middle of DRAIN aborts the job.
        load_identity_job();
        feed(0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("abort_ctl", RW'({out_valid_u, busy_u, in_ready_u, out_valid_s}), RW'(4'b0010));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_release", RW'({out_valid_u, busy_u, in_ready_u}), RW'(3'b001));
        load_identity_job();
        run_job(0, 0);

        // Random jobs against the sum-of-products model.
        for (int t = 0; t < 8; t++) begin
            jk = int'($urandom_range(1, KMAX));
            for (int k = 0; k < jk; k++)
                for (int l = 0; l < N; l++) begin
                    ja[k][l] = ($urandom_range(0, 3) == 0) ? 16'hFFFF - DW'($urandom_range(0, 2)) : DW'($urandom);
                    jb[k][l] = ($urandom_range(0, 3) == 0) ? 16'h8000 : DW'($urandom);
                end
            model_job();
            run_job(2, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
